mult_div_sequencer: RTL and testbench
=====================================

Name: mult_div_sequencer

Overview:
- Multi-cycle HI/LO multiply/divide unit with its own sequencer, sitting beside the EX-stage ALU.
- Accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO commands from EX and holds the pipeline via `busy` while an operation is in flight.
- Commits results to the architectural HI/LO registers after a fixed, parameterised latency.
- Supports cancellation of the in-flight operation on exception flush.

Parameters:
- MUL_CYCLES, 5, busy cycles for MULT/MULTU (legal range 1..31).
- DIV_CYCLES, 10, busy cycles for DIV/DIVU (legal range 1..31).

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  command valid this cycle.
- op  input  3  1=MULT, 2=MULTU, 3=DIV, 4=DIVU, 5=MTHI, 6=MTLO; 0 and 7 are no-ops.
- A  input  32  rs operand (dividend / multiplicand / MTHI or MTLO data).
- B  input  32  rt operand (divisor / multiplier).
- cancel  input  1  abort the in-flight operation (pipeline flush).
- busy  output  1  operation in flight; EX must stall any HI/LO access.
- hi  output  32  architectural HI register.
- lo  output  32  architectural LO register.

Behaviour:
- Reset: state=IDLE, counter=0, busy=0, hi=0, lo=0. Reset has priority over every other input, including mid-operation.
- States: IDLE, RUN.
- IDLE + start + op in {1..4}:
  - Latch A, B and op.
  - Load counter with MUL_CYCLES or DIV_CYCLES.
  - Go to RUN; busy=1 from the next cycle.
- IDLE + start + op=5: hi<=A at this edge; state stays IDLE; busy stays 0.
- IDLE + start + op=6: lo<=A at this edge; state stays IDLE; busy stays 0.
- IDLE + start + op in {0,7}: no effect.
- RUN:
  - Counter decrements each cycle.
  - On the edge where counter==1: write hi/lo with the result and return to IDLE; busy=0 the following cycle.
  - Net latency: start accepted at edge t; busy=1 during the N cycles after t; new hi/lo and busy=0 visible together after edge t+N.
- start while in RUN is ignored; the issuer must hold the command until busy=0.
- A start presented in the first cycle busy=0 is accepted normally, back to back.
- cancel in RUN: return to IDLE next edge; hi/lo unchanged; busy=0 next cycle.
- cancel in IDLE: no effect. cancel together with start in IDLE: start is dropped.
- cancel on the final RUN cycle: cancel wins; no commit.
- Arithmetic rules:
  - MULT: {hi,lo} = signed64(A) * signed64(B).
  - MULTU: {hi,lo} = zero-extended unsigned product.
  - DIVU: lo=A/B, hi=A%B.
  - DIV: quotient truncates toward zero; remainder takes the sign of the dividend.
- Boundary cases:
  - Divide by zero (DIV or DIVU): lo=32'hFFFFFFFF, hi=A.
  - DIV with A=32'h80000000 and B=32'hFFFFFFFF: lo=32'h80000000, hi=0.
- Result computation: may be iterative (shift/add, restoring divide) or single-shot on the latched operands. The busy window and commit timing above are fixed regardless; only the final hi/lo values are visible.
- hi/lo never change except on MTHI/MTLO, on a completed operation, or on reset.

Test Plan:
- Reset, then MULT with A=32'hFFFFFFFE (-2), B=3 -> busy high exactly 5 cycles; then hi=32'hFFFFFFFF, lo=32'hFFFFFFFA, busy=0.
- MULTU with A=B=32'hFFFFFFFF -> after 5 busy cycles hi=32'hFFFFFFFE, lo=1.
- DIV with A=-7, B=2 -> busy 10 cycles; lo=32'hFFFFFFFD, hi=32'hFFFFFFFF. Then DIVU with A=7, B=0 -> lo=32'hFFFFFFFF, hi=7.
- DIV with A=32'h80000000, B=-1 -> lo=32'h80000000, hi=0.
- MTHI A=32'h1234 -> hi=32'h1234 next cycle with busy never asserted. Then a DIV started, with cancel on busy cycle 10 -> busy=0 next cycle, hi still 32'h1234.
- Back-to-back and reset cases:
  - MULT issued, then a second start held throughout busy -> the second op is accepted in the first busy=0 cycle.
  - reset asserted on the 3rd busy cycle -> next cycle busy=0, hi=lo=0, state IDLE.

Source files
------------

// File: rtl/mult_div_sequencer.sv
// HI/LO multiply/divide unit: accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO commands, holds the
// pipeline via busy for a fixed latency, then commits the result to HI/LO.
module mult_div_sequencer #(
  parameter int MUL_CYCLES = 5,
  parameter int DIV_CYCLES = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        cancel,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  // Command protocol: start/op/A/B form one command, consumed at the rising edge only when
  // the unit is idle and cancel is low; while busy=1 the issuer holds the command unchanged.
  typedef enum logic {IDLE, RUN} state_t;

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  state_t      state, state_next;
  logic [4:0]  cnt, cnt_next;
  logic [2:0]  op_q;
  logic [31:0] a_q, b_q;
  logic        load;
  logic        hi_we, lo_we;
  logic [31:0] hi_d, lo_d;

  logic signed [63:0] prod_s;
  logic [63:0]        prod_u;
  logic [31:0]        abs_a, abs_b, quo_u, rem_u;
  logic [31:0]        res_hi, res_lo;

  // Result is computed single-shot from the latched operands; only the commit edge matters.
  assign prod_s = $signed({{32{a_q[31]}}, a_q}) * $signed({{32{b_q[31]}}, b_q});
  assign prod_u = {32'd0, a_q} * {32'd0, b_q};

  always_comb begin
    abs_a  = a_q;
    abs_b  = b_q;
    if (op_q == OP_DIV) begin
      abs_a = a_q[31] ? -a_q : a_q;
      abs_b = b_q[31] ? -b_q : b_q;
    end
    quo_u  = 32'd0;
    rem_u  = 32'd0;
    if (abs_b != 32'd0) begin
      quo_u = abs_a / abs_b;
      rem_u = abs_a % abs_b;
    end
    res_hi = 32'd0;
    res_lo = 32'd0;
    case (op_q)
      OP_MULT:  {res_hi, res_lo} = prod_s;
      OP_MULTU: {res_hi, res_lo} = prod_u;
      OP_DIV, OP_DIVU: begin
        if (b_q == 32'd0) begin
          res_hi = a_q;
          res_lo = 32'hFFFF_FFFF;
        end else if (op_q == OP_DIV) begin
          // Magnitude divide, then re-sign; -2^31 / -1 falls out as 0x80000000 rem 0.
          res_lo = (a_q[31] ^ b_q[31]) ? -quo_u : quo_u;
          res_hi = a_q[31] ? -rem_u : rem_u;
        end else begin
          res_lo = quo_u;
          res_hi = rem_u;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    load       = 1'b0;
    hi_we      = 1'b0;
    lo_we      = 1'b0;
    hi_d       = res_hi;
    lo_d       = res_lo;
    case (state)
      IDLE: begin
        if (start && !cancel) begin
          case (op)
            OP_MULT, OP_MULTU: begin
              load       = 1'b1;
              cnt_next   = 5'(MUL_CYCLES);
              state_next = RUN;
            end
            OP_DIV, OP_DIVU: begin
              load       = 1'b1;
              cnt_next   = 5'(DIV_CYCLES);
              state_next = RUN;
            end
            OP_MTHI: begin
              hi_we = 1'b1;
              hi_d  = A;
            end
            OP_MTLO: begin
              lo_we = 1'b1;
              lo_d  = A;
            end
            default: ;
          endcase
        end
      end
      RUN: begin
        if (cancel) begin
          state_next = IDLE;
          cnt_next   = 5'd0;
        end else if (cnt == 5'd1) begin
          hi_we      = 1'b1;
          lo_we      = 1'b1;
          state_next = IDLE;
          cnt_next   = 5'd0;
        end else begin
          cnt_next = cnt - 5'd1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= 5'd0;
      op_q  <= 3'd0;
      a_q   <= 32'd0;
      b_q   <= 32'd0;
      hi    <= 32'd0;
      lo    <= 32'd0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      if (load) begin
        op_q <= op;
        a_q  <= A;
        b_q  <= B;
      end
      if (hi_we) hi <= hi_d;
      if (lo_we) lo <= lo_d;
    end
  end

  assign busy = (state == RUN);

endmodule

// File: tb/tb_mult_div_sequencer.sv
// Self-checking bench for mult_div_sequencer: directed cases from the plan plus random
// arithmetic, with expected {hi,lo} queued at issue and compared at commit.
module tb_mult_div_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  op;
  logic [31:0] A, B;
  logic        cancel;
  logic        busy;
  logic [31:0] hi, lo;

  logic [63:0] exp_q[$];
  int n_tests = 0;
  int n_fail  = 0;

  mult_div_sequencer #(.MUL_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .A(A), .B(B),
    .cancel(cancel), .busy(busy), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference model written with native signed arithmetic.
  function automatic logic [63:0] model(input logic [2:0] o, input logic [31:0] a,
                                        input logic [31:0] b);
    longint sa, sb;
    longint unsigned ua, ub;
    int q, r;
    case (o)
      3'd1: begin
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        return 64'(sa * sb);
      end
      3'd2: begin
        ua = {32'd0, a};
        ub = {32'd0, b};
        return ua * ub;
      end
      3'd3: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
        q = $signed(a) / $signed(b);
        r = $signed(a) % $signed(b);
        return {32'(r), 32'(q)};
      end
      3'd4: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        return {a % b, a / b};
      end
      default: return 64'd0;
    endcase
  endfunction

  // Counts busy cycles seen at negedges; bounded so a stuck busy cannot hang the run.
  task automatic count_busy(output int n);
    n = 0;
    while (busy === 1'b1 && n < 100) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] a,
                        input logic [31:0] b, input int cycles);
    int n;
    logic [63:0] e;
    @(negedge clk);
    start = 1'b1; op = o; A = a; B = b;
    exp_q.push_back(model(o, a, b));
    @(negedge clk);
    start = 1'b0;
    count_busy(n);
    check({tag, "_busy_len"}, 64'(n), 64'(cycles));
    e = exp_q.pop_front();
    check({tag, "_hilo"}, {hi, lo}, e);
  endtask

  initial begin
    int n;
    logic [2:0] ro;
    logic [31:0] ra, rb;
    logic [63:0] e;

    reset = 1'b1; start = 1'b0; op = 3'd0; A = 32'd0; B = 32'd0; cancel = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    check("reset_state", {31'd0, busy, hi}, {31'd0, 1'b0, 32'd0});
    check("reset_lo", 64'(lo), 64'd0);

    run_op("mult_neg", 3'd1, 32'hFFFF_FFFE, 32'd3, 5);
    run_op("multu_max", 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5);
    run_op("div_neg7", 3'd3, 32'hFFFF_FFF9, 32'd2, 10);
    run_op("divu_zero", 3'd4, 32'd7, 32'd0, 10);
    run_op("div_ovf", 3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 10);
    run_op("div_zero", 3'd3, 32'hFFFF_FF00, 32'd0, 10);

    // MTHI / MTLO complete in one edge without asserting busy.
    @(negedge clk);
    start = 1'b1; op = 3'd5; A = 32'h1234;
    @(negedge clk);
    start = 1'b0;
    check("mthi", {31'd0, busy, hi}, {31'd0, 1'b0, 32'h1234});
    start = 1'b1; op = 3'd6; A = 32'h5678;
    @(negedge clk);
    start = 1'b0;
    check("mtlo", {31'd0, busy, lo}, {31'd0, 1'b0, 32'h5678});

    // No-op codes and start dropped under cancel leave everything untouched.
    start = 1'b1; op = 3'd7; A = 32'hDEAD;
    @(negedge clk);
    op = 3'd3; cancel = 1'b1;
    @(negedge clk);
    start = 1'b0; cancel = 1'b0;
    @(negedge clk);
    check("noop_cancel_idle", {31'd0, busy, hi}, {31'd0, 1'b0, 32'h1234});

    // Cancel on the final busy cycle wins over the commit.
    start = 1'b1; op = 3'd3; A = 32'd100; B = 32'd7;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (busy === 1'b1 && n < 9) begin
      n++;
      @(negedge clk);
    end
    check("cancel_reach10", {63'd0, busy}, 64'd1);
    cancel = 1'b1;
    @(negedge clk);
    cancel = 1'b0;
    check("cancel_busy", {63'd0, busy}, 64'd0);
    check("cancel_hilo", {hi, lo}, {32'h1234, 32'h5678});

    // Back-to-back: second command held through busy is taken in the first idle cycle.
    @(negedge clk);
    start = 1'b1; op = 3'd1; A = 32'd6; B = 32'hFFFF_FFF9;
    exp_q.push_back(model(3'd1, 32'd6, 32'hFFFF_FFF9));
    @(negedge clk);
    op = 3'd4; A = 32'd1000; B = 32'd33;
    exp_q.push_back(model(3'd4, 32'd1000, 32'd33));
    count_busy(n);
    check("b2b_first_len", 64'(n), 64'd5);
    e = exp_q.pop_front();
    check("b2b_first_hilo", {hi, lo}, e);
    @(negedge clk);
    start = 1'b0;
    count_busy(n);
    check("b2b_second_len", 64'(n), 64'd10);
    e = exp_q.pop_front();
    check("b2b_second_hilo", {hi, lo}, e);

    // Reset mid-operation discards the operation and clears HI/LO.
    @(negedge clk);
    start = 1'b1; op = 3'd2; A = 32'hAAAA; B = 32'h5555;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    check("pre_reset_busy", {63'd0, busy}, 64'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("reset_mid", {31'd0, busy, hi}, {31'd0, 1'b0, 32'd0});
    check("reset_mid_lo", 64'(lo), 64'd0);

    // Random arithmetic with occasional zero divisors.
    for (int i = 0; i < 24; i++) begin
      ro = 3'($urandom_range(1, 4));
      ra = $urandom;
      rb = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom;
      if ($urandom_range(0, 2) == 0) rb = 32'($urandom_range(1, 50));
      run_op("rand", ro, ra, rb, (ro <= 3'd2) ? 5 : 10);
    end

    check("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
